// File: rtl/async_fifo_responder.sv
// async_fifo_responder
//   Shared FIFO with one push port and output_size independent pull ports.
//   Every written word is delivered to every port, in write order, over a
//   req/ack handshake. An entry is retired (its slot freed) only after all
//   ports have taken it, so a slow port eventually back-pressures the writer
//   once the array fills up, and not before.
//
// Ports
//   clk        single clock, all state updates on posedge
//   rst        synchronous active-high reset
//   din_valid  upstream word present on din
//   din_ready  a word can be accepted this cycle
//   din        upstream write data
//   req        per-port pull request
//   ack        per-port registered one-cycle acknowledge
//   dout       per-port registered data, port k at [data_width*(k+1)-1 : data_width*k]
//   level      occupied entries (written, not yet retired)
module async_fifo_responder #(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int output_size = 2,
    localparam int lw         = $clog2(depth) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             din_valid,
    output logic                             din_ready,
    input  logic [data_width-1:0]            din,
    input  logic [output_size-1:0]           req,
    output logic [output_size-1:0]           ack,
    output logic [data_width*output_size-1:0] dout,
    output logic [lw-1:0]                    level
);

    logic [data_width-1:0]  mem  [depth];
    logic [output_size-1:0] pend [depth];
    logic [lw-1:0]          rp   [output_size];
    logic [lw-1:0]          wp;
    logic [lw-1:0]          fp;

    logic                   wr_en;
    logic                   retire;
    logic [output_size-1:0] serve;

    always_comb begin
        level     = wp - fp;
        din_ready = (level != lw'(depth)) && !rst;
        wr_en     = din_valid && din_ready;
        // Oldest entry may be freed once every port has cleared its pending bit.
        retire    = (level != '0) && (pend[fp[lw-2:0]] == '0);
        serve     = '0;
        for (int unsigned k = 0; k < output_size; k++) begin
            serve[k] = req[k] && !ack[k] && (rp[k] != wp);
        end
    end

    // Storage is not cleared by reset; wr_en already excludes rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp[lw-2:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp   <= '0;
            fp   <= '0;
            ack  <= '0;
            dout <= '0;
            for (int unsigned k = 0; k < output_size; k++) begin
                rp[k] <= '0;
            end
            for (int unsigned e = 0; e < depth; e++) begin
                pend[e] <= '0;
            end
        end else begin
            ack <= serve;
            for (int unsigned k = 0; k < output_size; k++) begin
                if (serve[k]) begin
                    dout[k*data_width +: data_width] <= mem[rp[k][lw-2:0]];
                    rp[k]                            <= rp[k] + lw'(1);
                    pend[rp[k][lw-2:0]][k]           <= 1'b0;
                end
            end
            // A write never targets an entry a port is reading: rp != wp,
            // and the only aliasing slot (full array) blocks the write.
            if (wr_en) begin
                pend[wp[lw-2:0]] <= '1;
                wp               <= wp + lw'(1);
            end
            if (retire) begin
                fp <= fp + lw'(1);
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_responder.sv
// tb_async_fifo_responder
//   Scoreboard bench for async_fifo_responder (32-bit, depth 4, 2 ports).
//   A reference model counts words written, retired and consumed per port and
//   pushes each accepted word into a per-port expected queue; a monitor on the
//   falling edge pops and compares whenever the DUT acknowledges.
module tb_async_fifo_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NP    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [DW-1:0] din = '0;
    logic [NP-1:0] req = '0;
    logic [NP-1:0] ack;
    logic [DW*NP-1:0] dout;
    logic [2:0]    level;

    always #5 clk = ~clk;

    async_fifo_responder #(
        .data_width (DW),
        .depth      (DEPTH),
        .output_size(NP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .din      (din),
        .req      (req),
        .ack      (ack),
        .dout     (dout),
        .level    (level)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: absolute counts of writes, retirements and per-port pulls.
    int            wr = 0;
    int            ret = 0;
    int            cons [NP] = '{0, 0};
    logic [NP-1:0] m_ack = '0;
    logic [DW-1:0] m_dout [NP] = '{'0, '0};
    bit            m_wrote = 1'b0;
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    function automatic bit model_ready();
        return !rst && ((wr - ret) != DEPTH);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model step at each rising edge, using the inputs presented before it.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                wr = 0;
                ret = 0;
                cons[0] = 0;
                cons[1] = 0;
                m_ack = '0;
                m_dout[0] = '0;
                m_dout[1] = '0;
                m_wrote = 1'b0;
                q0.delete();
                q1.delete();
            end else begin
                bit do_ret;
                bit do_wr;
                // Oldest word leaves once both ports took it on an earlier edge.
                do_ret = ((wr - ret) > 0) && (cons[0] > ret) && (cons[1] > ret);
                do_wr  = din_valid && ((wr - ret) != DEPTH);
                for (int k = 0; k < NP; k++) begin
                    if (req[k] && !m_ack[k] && (cons[k] < wr)) begin
                        m_ack[k] = 1'b1;
                        cons[k]++;
                    end else begin
                        m_ack[k] = 1'b0;
                    end
                end
                if (do_wr) begin
                    q0.push_back(din);
                    q1.push_back(din);
                    wr++;
                end
                if (do_ret) ret++;
                m_wrote = do_wr;
            end
        end
    end

    // Monitor: compare on the falling edge, pop on each acknowledge.
    initial begin
        forever begin
            @(negedge clk);
            check("ack", 64'(ack), 64'(m_ack));
            for (int k = 0; k < NP; k++) begin
                logic [DW-1:0] got;
                got = dout[k*DW +: DW];
                if (ack[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_ack port %0d: got data %0h, expected no word at %0t", k, got, $time);
                    end else begin
                        logic [DW-1:0] v;
                        v = (k == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("dout_%0d", k), 64'(got), 64'(v));
                        m_dout[k] = v;
                    end
                end else begin
                    check($sformatf("dout_hold_%0d", k), 64'(got), 64'(m_dout[k]));
                end
            end
            check("level", 64'(level), 64'(wr - ret));
            check("din_ready", 64'(din_ready), 64'(model_ready()));
        end
    end

    task automatic step(input bit dv, input logic [DW-1:0] d, input logic [NP-1:0] r);
        din_valid = dv;
        din = d;
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int cyc;

        rst = 1'b1;
        repeat (3) step(1'b1, 32'hdead, 2'b11);
        rst = 1'b0;
        #1;

        // Single word to both ports, then retire.
        step(1'b1, 32'd10, 2'b00);
        step(1'b0, '0, 2'b11);
        step(1'b0, '0, 2'b00);
        step(1'b0, '0, 2'b00);
        check("single_level", 64'(level), 64'd0);

        // Fill, then an extra write that must be ignored.
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 2'b00);
        step(1'b1, 32'd5, 2'b00);
        step(1'b0, '0, 2'b00);
        check("full_level", 64'(level), 64'd4);
        check("full_ready", 64'(din_ready), 64'd0);

        // Port 0 drains its view; port 1 has not pulled so nothing retires.
        repeat (8) step(1'b0, '0, 2'b01);
        check("slow_level", 64'(level), 64'd4);
        step(1'b0, '0, 2'b10);
        step(1'b0, '0, 2'b00);
        check("retire_level", 64'(level), 64'd3);
        check("retire_ready", 64'(din_ready), 64'd1);
        repeat (8) step(1'b0, '0, 2'b10);
        repeat (4) step(1'b0, '0, 2'b00);

        // Long stream with both ports pulling continuously.
        n = 0;
        cyc = 0;
        while (n < 5000 && cyc < 40000) begin
            step(1'b1, DW'(n), 2'b11);
            if (m_wrote) n++;
            cyc++;
        end
        vectors++;
        if (n < 5000) begin
            miscompares++;
            $display("FAIL stream_timeout: got %0d words written, expected 5000", n);
        end
        repeat (12) step(1'b0, '0, 2'b11);

        // Stalled request on an empty block.
        repeat (20) step(1'b0, '0, 2'b01);
        step(1'b1, 32'd7, 2'b01);
        step(1'b0, '0, 2'b01);
        step(1'b0, '0, 2'b00);
        repeat (3) step(1'b0, '0, 2'b10);

        // Reset in the middle of a pull.
        for (int i = 1; i <= 3; i++) step(1'b1, DW'(i), 2'b00);
        step(1'b0, '0, 2'b01);
        step(1'b0, '0, 2'b01);
        rst = 1'b1;
        step(1'b1, 32'd55, 2'b11);
        rst = 1'b0;
        #1;
        step(1'b0, '0, 2'b00);
        check("post_rst_level", 64'(level), 64'd0);
        step(1'b1, 32'd99, 2'b00);
        step(1'b0, '0, 2'b11);
        step(1'b0, '0, 2'b00);
        repeat (2) step(1'b0, '0, 2'b00);

        // Random traffic with occasional resets.
        repeat (3000) begin
            logic [NP-1:0] r;
            r[0] = ($urandom_range(0, 3) != 0);
            r[1] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                step(1'b1, $urandom, r);
                rst = 1'b0;
                #1;
            end else begin
                step($urandom_range(0, 2) != 0, $urandom, r);
            end
        end
        repeat (24) step(1'b0, '0, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/async_fifo_responder.md
ASYNC_FIFO_RESPONDER -- requirements
Module: async_fifo_responder

Interface
REQ-001 Parameter data_width, default 32, width of every data word.
REQ-002 Parameter depth, default 4, number of storage entries; power of two, >= 2.
REQ-003 Parameter output_size, default 2, number of independent pulling consumer ports.
REQ-004 Parameter lw = log2(depth)+1 is the level width, derived from depth, not overridable.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 din_valid  input  1  upstream word present on din.
REQ-008 din_ready  output  1  block can accept a word this cycle.
REQ-009 din  input  data_width  upstream write data.
REQ-010 req  input  output_size  per-port pull request, same req/ack protocol that async_operator uses as requester.
REQ-011 ack  output  output_size  per-port registered one-cycle acknowledge.
REQ-012 dout  output  data_width*output_size  per-port registered data; port k occupies bits [data_width*(k+1)-1 : data_width*k].
REQ-013 level  output  lw  number of occupied entries (written, not yet retired).

Function
REQ-014 Storage: depth-entry array, write pointer wp and retire pointer fp (lw bits each, wrap modulo 2*depth), per-port read pointer rp[k] (lw bits), per-entry pending mask pend[e] (output_size bits).
REQ-015 level SHALL equal wp - fp (modulo 2^lw); din_ready SHALL equal (level != depth) and not rst, combinational from registered state.
REQ-016 Write: on a cycle with din_valid & din_ready, mem[wp[lw-2:0]] <= din, pend[that entry] <= all ones, wp <= wp+1.
REQ-017 din_valid while din_ready=0 SHALL be ignored; no write, no pointer change.
REQ-018 Port k available when rp[k] != wp (registered values).
REQ-019 Serve: on a cycle with req[k] & ~ack[k] & available, at that edge ack[k] <= 1, dout_k <= mem[rp[k]], rp[k] <= rp[k]+1, pend[rp[k] entry][k] <= 0.
REQ-020 ack[k] SHALL default to 0 every cycle; it is never high two consecutive cycles; dout_k SHALL hold its value until the next ack[k].
REQ-021 Requests with no available word SHALL stall: ack[k] stays 0, req may stay high indefinitely, nothing lost.
REQ-022 Ports SHALL be independent: any subset of ports may be served in the same cycle, each receiving words in write order; a slow port never blocks a fast port until the array is full.
REQ-023 Retire: when level != 0 and pend[fp entry] == 0, fp <= fp+1; at most one retire per cycle.
REQ-024 Latency: word written at edge N is ackable at edge N+1 earliest; retire after last port served at edge M occurs at edge M+1; din_ready rises in cycle after retire.
REQ-025 Simultaneous write and retire in one cycle SHALL both occur; level unchanged.
REQ-026 Simultaneous write and serve of a different entry SHALL both occur; no same-cycle bypass of the word being written.
REQ-027 Full: level == depth -> din_ready 0; pointer wrap at 2*depth SHALL keep full/empty distinguishable.

Reset
REQ-028 While rst=1: ack=0, dout=0, wp=fp=rp[k]=0, all pend=0, level=0, din_ready=0; req and din_valid ignored.
REQ-029 Reset asserted mid-transfer SHALL discard all stored words and pending acks; first cycle after rst deasserts din_ready=1, level=0.

Verification (data_width=32, depth=4, output_size=2)
REQ-030 Write 10, both req high -> next edge ack=2'b11, dout_0=dout_1=10; one edge later level=0.
REQ-031 Write 1..4, no req -> level=4, din_ready=0; 5th din_valid ignored; level stays 4.
REQ-032 Full with 1..4; port 0 pulls 4 words, port 1 none -> dout_0 sequence 1,2,3,4; level stays 4, din_ready=0; port 1 pulls once -> dout_1=1, next edge level=3, din_ready=1.
REQ-033 Stream 5000 words 0..4999, both ports req held high -> each port receives all values in order, no duplicates, ack never high two consecutive cycles.
REQ-034 Port 0 req held high on empty block for 20 cycles -> ack_0=0 throughout; write 7 -> ack_0 one edge later with dout_0=7.
REQ-035 Load 3 words, assert rst for one cycle mid-pull -> ack=0, dout=0 during rst, level=0 after; next written value 99 is the first word delivered on both ports.
